// File: rtl/ctrl_route_unit_pkg.sv
// Shared constants, types and opcode decode for the control-path router.
package ctrl_route_unit_pkg;

  localparam int REG_WIDTH  = 8;
  localparam int ADDR_WIDTH = 16;
  localparam int NUM_SRC    = 11;
  localparam int NUM_DST    = 11;
  localparam int WE_W       = 7;

  localparam int WE_PC   = 0;
  localparam int WE_SP   = 1;
  localparam int WE_ADD  = 2;
  localparam int WE_X    = 3;
  localparam int WE_Y    = 4;
  localparam int WE_STAT = 5;
  localparam int WE_DOUT = 6;

  localparam logic [3:0] SEL_PC     = 4'd0;
  localparam logic [3:0] SEL_SP     = 4'd1;
  localparam logic [3:0] SEL_ADD    = 4'd2;
  localparam logic [3:0] SEL_X      = 4'd3;
  localparam logic [3:0] SEL_Y      = 4'd4;
  localparam logic [3:0] SEL_STAT   = 4'd5;
  localparam logic [3:0] SEL_MEM    = 4'd6;
  localparam logic [3:0] SEL_IMM    = 4'd7;
  localparam logic [3:0] SEL_FETCH  = 4'd8;
  localparam logic [3:0] SEL_DECODE = 4'd9;
  localparam logic [3:0] SEL_ALU    = 4'd10;
  localparam logic [3:0] SEL_NONE   = 4'd15;

  // Crossbar destination slots
  localparam int DST_PC     = 0;
  localparam int DST_SP     = 1;
  localparam int DST_ADD    = 2;
  localparam int DST_X      = 3;
  localparam int DST_Y      = 4;
  localparam int DST_STAT   = 5;
  localparam int DST_MEM    = 6;
  localparam int DST_FETCH  = 7;
  localparam int DST_DECODE = 8;
  localparam int DST_ALU0   = 9;
  localparam int DST_ALU1   = 10;

  localparam logic [7:0] OP_LDA_IMM = 8'hA9;
  localparam logic [7:0] OP_LDX_IMM = 8'hA2;
  localparam logic [7:0] OP_LDY_IMM = 8'hA0;
  localparam logic [7:0] OP_LDA_ZPG = 8'hA5;
  localparam logic [7:0] OP_LDX_ZPG = 8'hA6;
  localparam logic [7:0] OP_LDY_ZPG = 8'hA4;
  localparam logic [7:0] OP_STA_ZPG = 8'h85;
  localparam logic [7:0] OP_STX_ZPG = 8'h86;
  localparam logic [7:0] OP_STY_ZPG = 8'h84;
  localparam logic [7:0] OP_TAX     = 8'hAA;
  localparam logic [7:0] OP_TAY     = 8'hA8;
  localparam logic [7:0] OP_TXA     = 8'h8A;
  localparam logic [7:0] OP_TYA     = 8'h98;
  localparam logic [7:0] OP_NOP     = 8'hEA;

  typedef enum logic [1:0] {ST_IDLE, ST_MEM, ST_EXEC} state_t;

  typedef struct packed {
    logic            legal;
    logic            zpg_load;
    logic            mem_addr_en;
    logic [WE_W-1:0] we;
    logic [3:0]      sel_add;
    logic [3:0]      sel_x;
    logic [3:0]      sel_y;
    logic [3:0]      sel_mem;
  } op_ctrl_t;

  function automatic op_ctrl_t decode_op(input logic [7:0] op);
    op_ctrl_t c;
    c.legal       = 1'b1;
    c.zpg_load    = 1'b0;
    c.mem_addr_en = 1'b0;
    c.we          = '0;
    c.sel_add     = SEL_NONE;
    c.sel_x       = SEL_NONE;
    c.sel_y       = SEL_NONE;
    c.sel_mem     = SEL_NONE;
    case (op)
      OP_LDA_IMM: begin c.sel_add = SEL_IMM; c.we[WE_ADD] = 1'b1; end
      OP_LDX_IMM: begin c.sel_x   = SEL_IMM; c.we[WE_X]   = 1'b1; end
      OP_LDY_IMM: begin c.sel_y   = SEL_IMM; c.we[WE_Y]   = 1'b1; end
      OP_LDA_ZPG: begin
        c.zpg_load = 1'b1; c.mem_addr_en = 1'b1; c.sel_add = SEL_MEM; c.we[WE_ADD] = 1'b1;
      end
      OP_LDX_ZPG: begin
        c.zpg_load = 1'b1; c.mem_addr_en = 1'b1; c.sel_x = SEL_MEM; c.we[WE_X] = 1'b1;
      end
      OP_LDY_ZPG: begin
        c.zpg_load = 1'b1; c.mem_addr_en = 1'b1; c.sel_y = SEL_MEM; c.we[WE_Y] = 1'b1;
      end
      OP_STA_ZPG: begin c.mem_addr_en = 1'b1; c.sel_mem = SEL_ADD; c.we[WE_DOUT] = 1'b1; end
      OP_STX_ZPG: begin c.mem_addr_en = 1'b1; c.sel_mem = SEL_X;   c.we[WE_DOUT] = 1'b1; end
      OP_STY_ZPG: begin c.mem_addr_en = 1'b1; c.sel_mem = SEL_Y;   c.we[WE_DOUT] = 1'b1; end
      OP_TAX:     begin c.sel_x   = SEL_ADD; c.we[WE_X]   = 1'b1; end
      OP_TAY:     begin c.sel_y   = SEL_ADD; c.we[WE_Y]   = 1'b1; end
      OP_TXA:     begin c.sel_add = SEL_X;   c.we[WE_ADD] = 1'b1; end
      OP_TYA:     begin c.sel_add = SEL_Y;   c.we[WE_ADD] = 1'b1; end
      OP_NOP:     ;
      default:    c.legal = 1'b0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/ctrl_route_unit_if.sv
// Fetcher / register-file / memory side bundle of the control-path router.
interface ctrl_route_unit_if #(
  parameter int REG_WIDTH  = ctrl_route_unit_pkg::REG_WIDTH,
  parameter int ADDR_WIDTH = ctrl_route_unit_pkg::ADDR_WIDTH
);
  logic [REG_WIDTH-1:0]  pc_in, sp_in, add_in, x_in, y_in, stat_in;
  logic [REG_WIDTH-1:0]  mem_in, imm_in, fetch_in, alu_in;
  logic [3:0]            fetch_selector;
  logic [7:0]            instruction_in;
  logic                  instruction_ready;

  logic [REG_WIDTH-1:0]  pc_out, sp_out, add_out, x_out, y_out, stat_out;
  logic [REG_WIDTH-1:0]  mem_out, fetch_out, decode_out, alu0_out, alu1_out;
  logic [6:0]            we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [7:0]            opp;
  logic                  instruction_done;
  logic                  illegal;

  modport master (
    output pc_in, sp_in, add_in, x_in, y_in, stat_in, mem_in, imm_in, fetch_in, alu_in,
    output fetch_selector, instruction_in, instruction_ready,
    input  pc_out, sp_out, add_out, x_out, y_out, stat_out, mem_out, fetch_out,
    input  decode_out, alu0_out, alu1_out, we, mem_addr, opp, instruction_done, illegal
  );

  modport slave (
    input  pc_in, sp_in, add_in, x_in, y_in, stat_in, mem_in, imm_in, fetch_in, alu_in,
    input  fetch_selector, instruction_in, instruction_ready,
    output pc_out, sp_out, add_out, x_out, y_out, stat_out, mem_out, fetch_out,
    output decode_out, alu0_out, alu1_out, we, mem_addr, opp, instruction_done, illegal
  );
endinterface

// File: rtl/ctrl_route_unit_route_xbar.sv
// Combinational 11x11 crossbar; any selector outside the source range yields zero.
module ctrl_route_unit_route_xbar
  import ctrl_route_unit_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [NUM_SRC-1:0][W-1:0] src_i,
  input  logic [NUM_DST-1:0][3:0]   sel_i,
  output logic [NUM_DST-1:0][W-1:0] dst_o
);

  always_comb begin
    dst_o = '0;
    for (int d = 0; d < NUM_DST; d++) begin
      for (int s = 0; s < NUM_SRC; s++) begin
        if (sel_i[d] == 4'(s)) dst_o[d] = src_i[s];
      end
    end
  end

endmodule

// File: rtl/ctrl_route_unit.sv
// Control-path core: phase clocks, instruction decoder FSM and crossbar routing.
// state | meaning
// IDLE  | waiting for instruction_ready; opcode and operand latched on it
// MEM   | zero-page load address on mem_addr, memory read in flight
// EXEC  | selectors and we asserted, instruction_done pulsed
module ctrl_route_unit #(
  parameter int REG_WIDTH  = ctrl_route_unit_pkg::REG_WIDTH,
  parameter int ADDR_WIDTH = ctrl_route_unit_pkg::ADDR_WIDTH
) (
  input  logic             clk,
  input  logic             reset_n,
  output logic             phi1,
  output logic             phi2,
  ctrl_route_unit_if.slave bus
);
  import ctrl_route_unit_pkg::*;

  state_t                state_q;
  logic [7:0]            opp_q;
  logic [REG_WIDTH-1:0]  operand_q;
  logic [WE_W-1:0]       we_q;
  logic [3:0]            sel_add_q, sel_x_q, sel_y_q, sel_mem_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic                  done_q, illegal_q;

  logic [7:0]            op_sel;
  op_ctrl_t              dec;
  logic [ADDR_WIDTH-1:0] zpg_addr;

  logic [NUM_SRC-1:0][REG_WIDTH-1:0] src;
  logic [NUM_DST-1:0][3:0]           sel;
  logic [NUM_DST-1:0][REG_WIDTH-1:0] dst;

  assign phi1 = ~clk;
  assign phi2 = clk;

  // New opcode is decoded while idle, the latched one afterwards (MEM -> EXEC).
  assign op_sel   = (state_q == ST_IDLE) ? bus.instruction_in : opp_q;
  assign dec      = decode_op(op_sel);
  assign zpg_addr = {{(ADDR_WIDTH-REG_WIDTH){1'b0}}, bus.imm_in};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      opp_q      <= '0;
      operand_q  <= '0;
      we_q       <= '0;
      sel_add_q  <= SEL_NONE;
      sel_x_q    <= SEL_NONE;
      sel_y_q    <= SEL_NONE;
      sel_mem_q  <= SEL_NONE;
      mem_addr_q <= '0;
      done_q     <= 1'b0;
      illegal_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.instruction_ready) begin
            opp_q      <= bus.instruction_in;
            operand_q  <= bus.imm_in;
            mem_addr_q <= dec.mem_addr_en ? zpg_addr : '0;
            if (dec.zpg_load) begin
              state_q <= ST_MEM;
            end else begin
              state_q   <= ST_EXEC;
              we_q      <= dec.we;
              sel_add_q <= dec.sel_add;
              sel_x_q   <= dec.sel_x;
              sel_y_q   <= dec.sel_y;
              sel_mem_q <= dec.sel_mem;
              done_q    <= 1'b1;
              illegal_q <= ~dec.legal;
            end
          end
        end
        ST_MEM: begin
          state_q   <= ST_EXEC;
          we_q      <= dec.we;
          sel_add_q <= dec.sel_add;
          sel_x_q   <= dec.sel_x;
          sel_y_q   <= dec.sel_y;
          sel_mem_q <= dec.sel_mem;
          done_q    <= 1'b1;
          illegal_q <= ~dec.legal;
        end
        ST_EXEC: begin
          state_q    <= ST_IDLE;
          we_q       <= '0;
          sel_add_q  <= SEL_NONE;
          sel_x_q    <= SEL_NONE;
          sel_y_q    <= SEL_NONE;
          sel_mem_q  <= SEL_NONE;
          mem_addr_q <= '0;
          done_q     <= 1'b0;
          illegal_q  <= 1'b0;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    src              = '0;
    src[SEL_PC]      = bus.pc_in;
    src[SEL_SP]      = bus.sp_in;
    src[SEL_ADD]     = bus.add_in;
    src[SEL_X]       = bus.x_in;
    src[SEL_Y]       = bus.y_in;
    src[SEL_STAT]    = bus.stat_in;
    src[SEL_MEM]     = bus.mem_in;
    src[SEL_IMM]     = bus.imm_in;
    src[SEL_FETCH]   = bus.fetch_in;
    src[SEL_DECODE]  = operand_q;
    src[SEL_ALU]     = bus.alu_in;
  end

  // Selectors the decoder never exercises stay parked at NONE.
  always_comb begin
    sel            = {NUM_DST{SEL_NONE}};
    sel[DST_ADD]   = sel_add_q;
    sel[DST_X]     = sel_x_q;
    sel[DST_Y]     = sel_y_q;
    sel[DST_MEM]   = sel_mem_q;
    sel[DST_FETCH] = bus.fetch_selector;
  end

  ctrl_route_unit_route_xbar #(.W(REG_WIDTH)) u_route_xbar (
    .src_i (src),
    .sel_i (sel),
    .dst_o (dst)
  );

  assign bus.pc_out     = dst[DST_PC];
  assign bus.sp_out     = dst[DST_SP];
  assign bus.add_out    = dst[DST_ADD];
  assign bus.x_out      = dst[DST_X];
  assign bus.y_out      = dst[DST_Y];
  assign bus.stat_out   = dst[DST_STAT];
  assign bus.mem_out    = dst[DST_MEM];
  assign bus.fetch_out  = dst[DST_FETCH];
  assign bus.decode_out = dst[DST_DECODE];
  assign bus.alu0_out   = dst[DST_ALU0];
  assign bus.alu1_out   = dst[DST_ALU1];

  assign bus.we               = we_q;
  assign bus.mem_addr         = mem_addr_q;
  assign bus.opp              = opp_q;
  assign bus.instruction_done = done_q;
  assign bus.illegal          = illegal_q;

endmodule

// File: tb/tb_ctrl_route_unit.sv
// Directed-vector bench for ctrl_route_unit with hand-computed expectations.
module tb_ctrl_route_unit;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic phi1, phi2;
  int   n_checks = 0;
  int   n_pass = 0;

  ctrl_route_unit_if bus_if ();

  ctrl_route_unit dut (
    .clk     (clk),
    .reset_n (reset_n),
    .phi1    (phi1),
    .phi2    (phi2),
    .bus     (bus_if)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [7:0] op, input logic [7:0] imm);
    bus_if.instruction_in    = op;
    bus_if.imm_in            = imm;
    bus_if.instruction_ready = 1'b1;
    tick();
    bus_if.instruction_ready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bus_if.pc_in = 8'h11;   bus_if.sp_in = 8'h22;   bus_if.add_in = 8'hC4;
    bus_if.x_in = 8'h33;    bus_if.y_in = 8'h5A;    bus_if.stat_in = 8'h66;
    bus_if.mem_in = 8'h7E;  bus_if.imm_in = 8'h00;  bus_if.fetch_in = 8'h99;
    bus_if.alu_in = 8'hAB;  bus_if.fetch_selector = 4'd15;
    bus_if.instruction_in = 8'hEA; bus_if.instruction_ready = 1'b0;

    tick(); tick();
    check_eq("rst_we",       32'(bus_if.we), 'h0);
    check_eq("rst_mem_addr", 32'(bus_if.mem_addr), 'h0);
    check_eq("rst_done",     32'(bus_if.instruction_done), 'h0);
    check_eq("rst_illegal",  32'(bus_if.illegal), 'h0);
    check_eq("rst_opp",      32'(bus_if.opp), 'h0);
    check_eq("rst_add_out",  32'(bus_if.add_out), 'h0);
    check_eq("rst_mem_out",  32'(bus_if.mem_out), 'h0);
    check_eq("rst_alu0_out", 32'(bus_if.alu0_out), 'h0);
    check_eq("rst_fetch_out",32'(bus_if.fetch_out), 'h0);
    check_eq("phi2_high",    32'(phi2), 'h1);
    check_eq("phi1_low",     32'(phi1), 'h0);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    check_eq("phi1_high",    32'(phi1), 'h1);
    tick();

    // LDA #$5C
    issue(8'hA9, 8'h5C);
    check_eq("lda_imm_add_out", 32'(bus_if.add_out), 'h5C);
    check_eq("lda_imm_we",      32'(bus_if.we), 'h04);
    check_eq("lda_imm_done",    32'(bus_if.instruction_done), 'h1);
    check_eq("lda_imm_illegal", 32'(bus_if.illegal), 'h0);
    check_eq("lda_imm_opp",     32'(bus_if.opp), 'hA9);
    check_eq("lda_imm_x_out",   32'(bus_if.x_out), 'h0);
    tick();
    check_eq("lda_imm_done_drop", 32'(bus_if.instruction_done), 'h0);
    check_eq("lda_imm_we_drop",   32'(bus_if.we), 'h0);
    check_eq("lda_imm_add_idle",  32'(bus_if.add_out), 'h0);

    // LDA $03 with ready pulses during MEM and EXEC that must be ignored
    issue(8'hA5, 8'h03);
    check_eq("lda_zpg_mem_addr", 32'(bus_if.mem_addr), 'h0003);
    check_eq("lda_zpg_mem_we",   32'(bus_if.we), 'h0);
    check_eq("lda_zpg_mem_done", 32'(bus_if.instruction_done), 'h0);
    check_eq("lda_zpg_mem_add",  32'(bus_if.add_out), 'h0);
    bus_if.instruction_in    = 8'hAA;
    bus_if.imm_in            = 8'h77;
    bus_if.instruction_ready = 1'b1;
    tick();
    check_eq("lda_zpg_add_out",  32'(bus_if.add_out), 'h7E);
    check_eq("lda_zpg_we",       32'(bus_if.we), 'h04);
    check_eq("lda_zpg_done",     32'(bus_if.instruction_done), 'h1);
    check_eq("lda_zpg_addr_hold",32'(bus_if.mem_addr), 'h0003);
    check_eq("lda_zpg_opp",      32'(bus_if.opp), 'hA5);
    check_eq("lda_zpg_x_out",    32'(bus_if.x_out), 'h0);
    tick();
    check_eq("exec_ready_done",  32'(bus_if.instruction_done), 'h0);
    check_eq("exec_ready_we",    32'(bus_if.we), 'h0);
    check_eq("exec_ready_opp",   32'(bus_if.opp), 'hA5);
    check_eq("exec_ready_addr",  32'(bus_if.mem_addr), 'h0);
    bus_if.instruction_ready = 1'b0;
    tick();
    check_eq("no_queue_done",    32'(bus_if.instruction_done), 'h0);
    check_eq("no_queue_we",      32'(bus_if.we), 'h0);

    // STX $10
    issue(8'h86, 8'h10);
    check_eq("stx_mem_addr", 32'(bus_if.mem_addr), 'h0010);
    check_eq("stx_mem_out",  32'(bus_if.mem_out), 'h33);
    check_eq("stx_we",       32'(bus_if.we), 'h40);
    check_eq("stx_done",     32'(bus_if.instruction_done), 'h1);
    tick();

    // TAX, TYA
    issue(8'hAA, 8'h00);
    check_eq("tax_x_out", 32'(bus_if.x_out), 'hC4);
    check_eq("tax_we",    32'(bus_if.we), 'h08);
    check_eq("tax_done",  32'(bus_if.instruction_done), 'h1);
    check_eq("tax_addr",  32'(bus_if.mem_addr), 'h0);
    tick();
    issue(8'h98, 8'h00);
    check_eq("tya_add_out", 32'(bus_if.add_out), 'h5A);
    check_eq("tya_we",      32'(bus_if.we), 'h04);
    tick();

    // Illegal opcode, then fetcher-driven selector probes
    issue(8'hFF, 8'h21);
    check_eq("ill_illegal", 32'(bus_if.illegal), 'h1);
    check_eq("ill_done",    32'(bus_if.instruction_done), 'h1);
    check_eq("ill_we",      32'(bus_if.we), 'h0);
    check_eq("ill_opp",     32'(bus_if.opp), 'hFF);
    bus_if.fetch_selector = 4'd12;
    #1;
    check_eq("sel12_fetch_out", 32'(bus_if.fetch_out), 'h0);
    check_eq("none_alu0_out",   32'(bus_if.alu0_out), 'h0);
    tick();
    check_eq("ill_illegal_drop", 32'(bus_if.illegal), 'h0);
    check_eq("ill_done_drop",    32'(bus_if.instruction_done), 'h0);
    bus_if.fetch_selector = 4'd9;
    #1;
    check_eq("sel_decode_operand", 32'(bus_if.fetch_out), 'h21);
    bus_if.imm_in = 8'h4D;
    bus_if.fetch_selector = 4'd7;
    #1;
    check_eq("sel_imm_fetch_out", 32'(bus_if.fetch_out), 'h4D);
    bus_if.fetch_selector = 4'd10;
    #1;
    check_eq("sel_alu_fetch_out", 32'(bus_if.fetch_out), 'hAB);
    bus_if.fetch_selector = 4'd15;
    tick();

    // LDX $08 aborted by reset during MEM
    issue(8'hA6, 8'h08);
    check_eq("abort_mem_addr", 32'(bus_if.mem_addr), 'h0008);
    reset_n = 1'b0;
    #1;
    check_eq("abort_addr_clr", 32'(bus_if.mem_addr), 'h0);
    check_eq("abort_we",       32'(bus_if.we), 'h0);
    check_eq("abort_done",     32'(bus_if.instruction_done), 'h0);
    check_eq("abort_opp",      32'(bus_if.opp), 'h0);
    tick();
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    check_eq("abort_post_done", 32'(bus_if.instruction_done), 'h0);
    check_eq("abort_post_we",   32'(bus_if.we), 'h0);
    check_eq("abort_post_x",    32'(bus_if.x_out), 'h0);

    // LDY #$3C after recovery
    issue(8'hA0, 8'h3C);
    check_eq("ldy_imm_y_out", 32'(bus_if.y_out), 'h3C);
    check_eq("ldy_imm_we",    32'(bus_if.we), 'h10);
    check_eq("ldy_imm_done",  32'(bus_if.instruction_done), 'h1);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
